// File: rtl/arpeggiator_n.sv
// arpeggiator_n: cycles through held keys one at a time (up/down/up-down); bypasses key-ons when disabled.
// Latency: one registered cycle from keys to out in both bypass and arpeggiate modes.
// No backpressure. Optional key latch is compiled in when ARP_LATCH_EN is defined.
module arpeggiator_n #(
   parameter int NUM_KEYS = 8,
   parameter int CNT_W    = 16,
   parameter int IDX_W    = $clog2(NUM_KEYS)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                Enable,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic [1:0]          mode,
   input  logic [CNT_W-1:0]    step_len,
   input  logic [CNT_W-1:0]    gate_len,
   output logic [NUM_KEYS-1:0] out,
   output logic                step_strobe,
   output logic [IDX_W-1:0]    cur_idx
);

   typedef enum logic [1:0] {RST, BYPASS, WAIT, PLAY} state_t;

   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_UPDN = 2'b10;
   localparam logic       DIR_UP    = 1'b0;
   localparam logic       DIR_DN    = 1'b1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    counter_q, counter_d;
   logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
   logic                dir_q, dir_d;
   logic [NUM_KEYS-1:0] out_q, out_d;
   logic                strobe_q, strobe_d;

   logic [NUM_KEYS-1:0] pattern;
   logic [NUM_KEYS-1:0] above_m, below_m;
   logic                dir_eff;
   logic [IDX_W-1:0]    bnd_idx, start_idx;
   logic                bnd_dir, start_dir;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_KEYS-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

`ifdef ARP_LATCH_EN
   // Latched pattern: accumulates while keys are held, survives full release,
   // and is replaced by the first chord pressed after a full release.
   logic [NUM_KEYS-1:0] pattern_q, pattern_d;
   logic                held_q;

   // Next latched pattern; the FSM sees it combinationally so latency matches the unlatched build.
   always_comb begin
      pattern_d = pattern_q;
      if (!Enable) begin
         pattern_d = '0;
      end else if (|keys) begin
         pattern_d = held_q ? (pattern_q | keys) : keys;
      end
   end

   // Latch storage plus a flag remembering whether any key was held last cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pattern_q <= '0;
         held_q    <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         held_q    <= |keys;
      end
   end

   assign pattern = pattern_d;
`else
   assign pattern = keys;
`endif

   // Candidate next steps: set bits strictly above/below the current index, wrap targets, start index.
   always_comb begin
      above_m = '0;
      below_m = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         above_m[i] = pattern[i] && (i > int'(cur_idx_q));
         below_m[i] = pattern[i] && (i < int'(cur_idx_q));
      end

      // A mode change re-seeds direction at the boundary; up-down keeps its running direction.
      case (mode)
         MODE_DOWN: dir_eff = DIR_DN;
         MODE_UPDN: dir_eff = dir_q;
         default:   dir_eff = DIR_UP;
      endcase

      bnd_idx = cur_idx_q;
      bnd_dir = dir_eff;
      if (dir_eff == DIR_UP) begin
         if (|above_m) begin
            bnd_idx = lowest_set(above_m);
            bnd_dir = DIR_UP;
         end else if (mode == MODE_UPDN && |below_m) begin
            bnd_idx = highest_set(below_m);
            bnd_dir = DIR_DN;
         end else begin
            // Wrap (up mode) or single key left (up-down): restart from the bottom.
            bnd_idx = lowest_set(pattern);
            bnd_dir = (mode == MODE_UPDN) ? DIR_DN : DIR_UP;
         end
      end else begin
         if (|below_m) begin
            bnd_idx = highest_set(below_m);
            bnd_dir = DIR_DN;
         end else if (mode == MODE_UPDN && |above_m) begin
            bnd_idx = lowest_set(above_m);
            bnd_dir = DIR_UP;
         end else begin
            bnd_idx = highest_set(pattern);
            bnd_dir = (mode == MODE_UPDN) ? DIR_UP : DIR_DN;
         end
      end

      start_idx = (mode == MODE_DOWN) ? highest_set(pattern) : lowest_set(pattern);
      start_dir = (mode == MODE_DOWN) ? DIR_DN : DIR_UP;
   end

   // Next-state, step timing and registered output computation.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      cur_idx_d = cur_idx_q;
      dir_d     = dir_q;
      out_d     = '0;
      strobe_d  = 1'b0;

      case (state_q)
         RST: begin
            state_d   = BYPASS;
            counter_d = '0;
         end
         BYPASS: begin
            counter_d = '0;
            if (Enable) state_d = WAIT;
            else        out_d   = keys;
         end
         WAIT: begin
            counter_d = '0;
            if (!Enable) begin
               state_d = BYPASS;
               out_d   = keys;
            end else if (|pattern) begin
               state_d   = PLAY;
               cur_idx_d = start_idx;
               dir_d     = start_dir;
               strobe_d  = 1'b1;
            end
         end
         PLAY: begin
            if (!Enable) begin
               // Disable wins over a coincident step boundary.
               state_d   = BYPASS;
               counter_d = '0;
               out_d     = keys;
            end else if (~|pattern) begin
               state_d   = WAIT;
               counter_d = '0;
            end else if (counter_q >= step_len) begin
               counter_d = '0;
               cur_idx_d = bnd_idx;
               dir_d     = bnd_dir;
               strobe_d  = 1'b1;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
         default: state_d = RST;
      endcase

      // While playing, only the current key may sound, gated by step position and by the key itself.
      if (state_d == PLAY) begin
         out_d[cur_idx_d] = (counter_d < gate_len) && pattern[cur_idx_d];
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= RST;
         counter_q <= '0;
         cur_idx_q <= '0;
         dir_q     <= DIR_UP;
         out_q     <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         cur_idx_q <= cur_idx_d;
         dir_q     <= dir_d;
         out_q     <= out_d;
         strobe_q  <= strobe_d;
      end
   end

   assign out         = out_q;
   assign step_strobe = strobe_q;
   assign cur_idx     = cur_idx_q;

endmodule

// File: tb/tb_arpeggiator_n.sv
// Directed testbench for arpeggiator_n (NUM_KEYS=8): bypass, up/down/up-down patterns,
// gate and step-length edge cases, disable and reset during play, optional latch.
module tb_arpeggiator_n;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Enable;
   logic [7:0]  keys;
   logic [1:0]  mode;
   logic [15:0] step_len;
   logic [15:0] gate_len;
   logic [7:0]  out;
   logic        step_strobe;
   logic [2:0]  cur_idx;

   int checks = 0;
   int errors = 0;

   arpeggiator_n #(.NUM_KEYS(8), .CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .Enable(Enable), .keys(keys), .mode(mode),
      .step_len(step_len), .gate_len(gate_len),
      .out(out), .step_strobe(step_strobe), .cur_idx(cur_idx)
   );

   always #5 CLK = ~CLK;

   task automatic go_bypass();
      Enable = 1'b0;
      keys   = 8'h00;
      repeat (2) @(negedge CLK);
   endtask

   // Leaves the bench at the negedge of the first PLAY cycle.
   task automatic start_arp(input logic [7:0] k, input logic [1:0] m, input int sl, input int gl);
      go_bypass();
      mode     = m;
      step_len = 16'(sl);
      gate_len = 16'(gl);
      keys     = k;
      @(negedge CLK);
      Enable = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RESET = 1'b1; Enable = 1'b0; keys = 8'hFF; mode = 2'b00; step_len = 16'd3; gate_len = 16'd2;
      repeat (3) @(negedge CLK);
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
      checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", step_strobe); end
      checks++; if (cur_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", cur_idx); end
      RESET = 1'b0;
   endtask

   task automatic test_bypass();
      keys = 8'h5A;
      repeat (2) @(negedge CLK);
      checks++; if (out !== 8'h5A) begin errors++; $display("FAIL bypass_5a: got %h expected 5a", out); end
      checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL bypass_strobe: got %b expected 0", step_strobe); end
      keys = 8'h3C;
      @(negedge CLK);
      checks++; if (out !== 8'h3C) begin errors++; $display("FAIL bypass_3c: got %h expected 3c", out); end
      keys = 8'h00;
      @(negedge CLK);
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL bypass_00: got %h expected 00", out); end
   endtask

   task automatic test_up();
      int seq [4];
      logic [7:0] one, exp_out;
      int s, ph;
      seq = '{0, 2, 5, 0};
      one = 8'h01;
      start_arp(8'h25, 2'b00, 3, 2);
      for (int k = 0; k < 16; k++) begin
         s  = seq[k / 4];
         ph = k % 4;
         exp_out = (ph < 2) ? (one << s) : 8'h00;
         checks++; if (cur_idx !== 3'(s)) begin errors++; $display("FAIL up_idx c%0d: got %0d expected %0d", k, cur_idx, s); end
         checks++; if (out !== exp_out) begin errors++; $display("FAIL up_out c%0d: got %h expected %h", k, out, exp_out); end
         checks++; if (step_strobe !== (ph == 0)) begin errors++; $display("FAIL up_strobe c%0d: got %b expected %b", k, step_strobe, ph == 0); end
         @(negedge CLK);
      end
   endtask

   task automatic test_updown();
      int seq [8];
      logic [7:0] one;
      seq = '{0, 1, 4, 7, 4, 1, 0, 1};
      one = 8'h01;
      start_arp(8'h93, 2'b10, 1, 1);
      for (int s = 0; s < 8; s++) begin
         checks++; if (cur_idx !== 3'(seq[s])) begin errors++; $display("FAIL updown_idx s%0d: got %0d expected %0d", s, cur_idx, seq[s]); end
         checks++; if (step_strobe !== 1'b1 || out !== (one << seq[s])) begin
            errors++; $display("FAIL updown_out s%0d: got %b/%h expected 1/%h", s, step_strobe, out, one << seq[s]); end
         repeat (2) @(negedge CLK);
      end
      start_arp(8'h08, 2'b10, 1, 1);
      for (int s = 0; s < 3; s++) begin
         checks++; if (cur_idx !== 3'd3 || step_strobe !== 1'b1 || out !== 8'h08) begin
            errors++; $display("FAIL updown_single s%0d: got idx %0d strobe %b out %h expected 3/1/08", s, cur_idx, step_strobe, out); end
         repeat (2) @(negedge CLK);
      end
   endtask

   task automatic test_down();
      int seq [3];
      logic [7:0] one, exp_out;
      seq = '{7, 0, 7};
      one = 8'h01;
      // Legato: gate_len 4 exceeds step_len 3, so each key sounds all 4 cycles.
      start_arp(8'h81, 2'b01, 3, 4);
      for (int k = 0; k < 9; k++) begin
         exp_out = one << seq[k / 4];
         checks++; if (cur_idx !== 3'(seq[k / 4]) || out !== exp_out) begin
            errors++; $display("FAIL down c%0d: got idx %0d out %h expected %0d/%h", k, cur_idx, out, seq[k / 4], exp_out); end
         @(negedge CLK);
      end
`ifndef ARP_LATCH_EN
      keys = 8'h01;
      @(negedge CLK);
      checks++; if (out !== 8'h00 || cur_idx !== 3'd7 || step_strobe !== 1'b0) begin
         errors++; $display("FAIL down_release7: got out %h idx %0d strobe %b expected 00/7/0", out, cur_idx, step_strobe); end
      repeat (2) @(negedge CLK);
      checks++; if (cur_idx !== 3'd0 || out !== 8'h01 || step_strobe !== 1'b1) begin
         errors++; $display("FAIL down_next0: got idx %0d out %h strobe %b expected 0/01/1", cur_idx, out, step_strobe); end
      keys = 8'h00;
      @(negedge CLK);
      checks++; if (out !== 8'h00 || step_strobe !== 1'b0) begin
         errors++; $display("FAIL down_release_all: got out %h strobe %b expected 00/0", out, step_strobe); end
      @(negedge CLK);
      keys = 8'h10;
      @(negedge CLK);
      checks++; if (cur_idx !== 3'd4 || out !== 8'h10 || step_strobe !== 1'b1) begin
         errors++; $display("FAIL down_wait_play: got idx %0d out %h strobe %b expected 4/10/1", cur_idx, out, step_strobe); end
`endif
   endtask

   task automatic test_boundaries();
      // gate_len 0: strobes continue but nothing sounds.
      start_arp(8'h04, 2'b00, 2, 0);
      for (int k = 0; k < 6; k++) begin
         checks++; if (out !== 8'h00 || cur_idx !== 3'd2 || step_strobe !== (k % 3 == 0)) begin
            errors++; $display("FAIL silent c%0d: got out %h idx %0d strobe %b expected 00/2/%b", k, out, cur_idx, step_strobe, k % 3 == 0); end
         @(negedge CLK);
      end
      // step_len 0: a new step every cycle.
      start_arp(8'h03, 2'b00, 0, 1);
      for (int k = 0; k < 6; k++) begin
         checks++; if (cur_idx !== 3'(k % 2) || out !== ((k % 2 == 0) ? 8'h01 : 8'h02) || step_strobe !== 1'b1) begin
            errors++; $display("FAIL step0 c%0d: got idx %0d out %h strobe %b expected %0d", k, cur_idx, out, step_strobe, k % 2); end
         @(negedge CLK);
      end
   endtask

   task automatic test_enable_drop();
      start_arp(8'h25, 2'b00, 3, 2);
      repeat (3) @(negedge CLK);
      Enable = 1'b0;
      @(negedge CLK);
      checks++; if (step_strobe !== 1'b0 || cur_idx !== 3'd0) begin
         errors++; $display("FAIL enable_drop_step: got strobe %b idx %0d expected 0/0", step_strobe, cur_idx); end
      @(negedge CLK);
      checks++; if (out !== 8'h25) begin errors++; $display("FAIL enable_drop_bypass: got %h expected 25", out); end
   endtask

   task automatic test_reset_mid_play();
      start_arp(8'h25, 2'b00, 3, 2);
      repeat (4) @(negedge CLK);
      checks++; if (cur_idx !== 3'd2 || out !== 8'h04) begin
         errors++; $display("FAIL rst_pre: got idx %0d out %h expected 2/04", cur_idx, out); end
      RESET = 1'b1;
      @(negedge CLK);
      checks++; if (out !== 8'h00 || cur_idx !== 3'd0 || step_strobe !== 1'b0) begin
         errors++; $display("FAIL rst_mid: got out %h idx %0d strobe %b expected 00/0/0", out, cur_idx, step_strobe); end
      RESET = 1'b0;
      Enable = 1'b0;
      @(negedge CLK);
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL rst_exit: got %h expected 00", out); end
      @(negedge CLK);
      checks++; if (out !== 8'h25) begin errors++; $display("FAIL rst_bypass: got %h expected 25", out); end
   endtask

`ifdef ARP_LATCH_EN
   task automatic test_latch();
      int seq [3];
      logic [7:0] one;
      seq = '{2, 4, 2};
      one = 8'h01;
      start_arp(8'h14, 2'b00, 1, 1);
      keys = 8'h00;
      for (int s = 0; s < 3; s++) begin
         checks++; if (cur_idx !== 3'(seq[s]) || out !== (one << seq[s])) begin
            errors++; $display("FAIL latch_hold s%0d: got idx %0d out %h expected %0d", s, cur_idx, out, seq[s]); end
         repeat (2) @(negedge CLK);
      end
      keys = 8'h40;
      repeat (2) @(negedge CLK);
      for (int s = 0; s < 2; s++) begin
         checks++; if (cur_idx !== 3'd6 || out !== 8'h40) begin
            errors++; $display("FAIL latch_reload s%0d: got idx %0d out %h expected 6/40", s, cur_idx, out); end
         repeat (2) @(negedge CLK);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bypass();
      test_up();
      test_updown();
      test_down();
      test_boundaries();
      test_enable_drop();
      test_reset_mid_play();
`ifdef ARP_LATCH_EN
      test_latch();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arpeggiator_n.md
# arpeggiator_n

Parametrised N-key arpeggiator sitting between the key scanner and the voice/oscillator bank. While enabled, it cycles through the currently pressed keys one at a time in the selected direction, asserting one gated key-on per step. While disabled, it passes all key-ons straight through with one cycle of latency. It generalises the fixed 4-key up-only arpeggiator with configurable key count, direction modes, gate length, skipping of unpressed keys, and an optional latch.

## Interface
- NUM_KEYS, 8: number of key inputs/outputs (2..32).
- CNT_W, 16: width of step/gate timing counters.
- IDX_W, $clog2(NUM_KEYS): width of the step index.
- Reset is RESET, synchronous, active-high; clock is CLK.
- CLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- Enable  in  1  1 = arpeggiate, 0 = bypass.
- keys  in  NUM_KEYS  key-on levels, bit i = key i.
- mode  in  2  00 up, 01 down, 10 up-down, 11 treated as up.
- step_len  in  CNT_W  step period minus 1, in clock cycles.
- gate_len  in  CNT_W  cycles per step the output stays on.
- out  out  NUM_KEYS  gated key-on outputs (registered), at most one bit set when Enable=1.
- step_strobe  out  1  one-cycle pulse on the first cycle of each played step.
- cur_idx  out  IDX_W  index of the key being played.

## Operation
- States: RST, BYPASS, WAIT, PLAY.
- RST:
  - entered on RESET, and is the state while RESET=1.
  - next state is BYPASS.
- BYPASS:
  - out <= keys.
  - Enable=1 → WAIT, with counter cleared.
- WAIT (Enable=1, no key in pattern):
  - out=0.
  - when the pattern becomes non-zero → PLAY, with cur_idx = lowest set bit (mode up/up-down) or highest set bit (down), dir=up (down for mode down), counter=0, step_strobe=1.
- PLAY:
  - counter increments each cycle.
  - out[cur_idx] = (counter < gate_len) & pattern[cur_idx]; all other bits are 0.
  - At counter == step_len, the step ends:
    - counter <= 0.
    - cur_idx <= next set pattern bit in the current direction, wrapping modulo NUM_KEYS.
    - step_strobe pulses.
  - If the pattern is empty at the step end or at any cycle → WAIT, out=0 the next cycle.
  - A key released mid-step gates its output off immediately (next registered cycle). The step timing continues.
- Up-down:
  - dir flips when no set bit exists beyond cur_idx in the current direction.
  - The next step is the nearest set bit in the new direction, so endpoints are not repeated.
  - With a single key held, that key repeats.
- Enable=0 in any non-RST state → BYPASS next cycle; counter cleared.
- A mode change takes effect at the next step boundary. The direction is re-initialised: up for mode up, down for mode down, kept for up-down.
- Arithmetic:
  - counter is CNT_W bits, unsigned.
  - step_len=0 gives a 1-cycle step.
  - gate_len=0 gives a silent step; gate_len > step_len gives legato (on for the whole step).
- pattern = keys, unless latched (see Configuration).

## Timing
- Reset values: out=0, step_strobe=0, cur_idx=0, counter=0, state=RST; first non-RST cycle is BYPASS.
- BYPASS latency: keys→out is 1 cycle.
- WAIT→PLAY: out[cur_idx] rises 1 cycle after the first key appears in the pattern; step_strobe is high in that same cycle.
- Step period: exactly step_len+1 cycles; the on-time is min(gate_len, step_len+1) cycles.
- RESET mid-PLAY: all outputs are 0 the next cycle, regardless of Enable.
- Simultaneous step end and Enable falling: Enable wins (→ BYPASS).

## Configuration
- ARP_LATCH_EN defined:
  - While any key is held, pattern <= pattern | keys.
  - When all keys are released, pattern is retained and playing continues.
  - The first press after an all-released state loads pattern <= keys (clears the old pattern).
  - Enable=0 or RESET clears pattern.
- ARP_LATCH_EN undefined: pattern = keys combinationally; releasing all keys → WAIT.

## Test plan
- NUM_KEYS=8. Reset, then Enable=0, keys=8'h5A → out=8'h5A one cycle later; step_strobe stays 0.
- Enable=1, mode=up, keys=8'b0010_0101, step_len=3, gate_len=2 → cur_idx 0,2,5,0,… every 4 cycles; each key is on 2 cycles, off 2 cycles.
- mode=up-down, keys=8'b1001_0011 → cur_idx sequence 0,1,4,7,4,1,0,1; keys={3} only → 3,3,3.
- mode=down, keys=8'h81 → 7,0,7. Releasing key 7 mid-step → out[7] off next cycle and the next step plays 0. Releasing all keys → WAIT, out=0.
- RESET asserted mid-PLAY → out=0, cur_idx=0 next cycle; then BYPASS.
- With ARP_LATCH_EN: press keys 2 and 4, release all → 2,4 keep cycling; press key 6 → only 6 plays.
